// File: rtl/latch_rf_pkg.sv
// Shared types, parameter defaults and width helper for the latch register-file write scheduler.
package latch_rf_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Address width for a bank of n cells; never narrower than one bit.
  function automatic int unsigned calc_aw(input int unsigned n);
    calc_aw = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at ptr, ptr moves past the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (en_i && !found && valid_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((32'(idx) + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/latch_rf_wr_sched.sv
// Shares the latch bank write port among requesters, tracks not-yet-stable cells, halts on request.
// Optional read bypass of the previous cycle's write: define LATCH_RF_WR_BYPASS_EN.
module latch_rf_wr_sched
  import latch_rf_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter  int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int unsigned AW         = calc_aw(NUM_REGS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*AW-1:0]         req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REGS-1:0]           cell_we_o,
  output logic [DATA_WIDTH-1:0]         cell_wdata_o,
  output logic [NUM_REGS-1:0]           pending_o,
  input  logic                          halt_req_i,
  output logic                          halted_o
`ifdef LATCH_RF_WR_BYPASS_EN
  ,
  input  logic [AW-1:0]                 rd_addr_i,
  output logic                          byp_hit_o,
  output logic [DATA_WIDTH-1:0]         byp_data_o
`endif
);

  state_t                state_q, state_d;
  logic                  grant_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   we;
  logic [NUM_REGS-1:0]   pending_q;

  // Gating on rst_ni keeps the combinational outputs at zero during reset.
  assign grant_en = rst_ni && (state_q == RUN) && !halt_req_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (req_valid_i),
    .en_i    (grant_en),
    .gnt_o   (gnt)
  );

  // One-hot mux of the granted requester's address and data; zero when idle.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr_i[i*AW +: AW];
        sel_data = sel_data | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Cell 0 and out-of-range addresses decode to nothing, dropping the write.
  always_comb begin
    we = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      we[r] = (|gnt) && (sel_addr == AW'(r));
    end
  end

  assign req_ready_o  = gnt;
  assign cell_we_o    = we;
  assign cell_wdata_o = sel_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= we;
  end

  assign pending_o = pending_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Halt skips DRAIN when nothing was written in the previous cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req_i) state_d = (|pending_q) ? DRAIN : HALTED;
      end
      DRAIN: begin
        if (pending_q == '0) state_d = halt_req_i ? HALTED : RUN;
      end
      HALTED: begin
        if (!halt_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign halted_o = (state_q == HALTED);

`ifdef LATCH_RF_WR_BYPASS_EN
  logic [AW-1:0]         byp_addr_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_addr_q <= '0;
      byp_data_q <= '0;
    end else if (|we) begin
      byp_addr_q <= sel_addr;
      byp_data_q <= sel_data;
    end
  end

  // pending_q is one-hot, so a hit on it equals a match on the saved address.
  assign byp_hit_o  = (|pending_q) && (rd_addr_i == byp_addr_q);
  assign byp_data_o = byp_data_q;
`endif

endmodule

// File: tb/tb_latch_rf_wr_sched.sv
// Directed table-driven bench for latch_rf_wr_sched plus reset and bypass sequences.
module tb_latch_rf_wr_sched;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [19:0] req_addr_i;
  logic [127:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic [31:0] cell_we_o;
  logic [31:0] cell_wdata_o;
  logic [31:0] pending_o;
  logic        halt_req_i;
  logic        halted_o;
`ifdef LATCH_RF_WR_BYPASS_EN
  logic [4:0]  rd_addr_i;
  logic        byp_hit_o;
  logic [31:0] byp_data_o;
`endif

  int n_cmp;
  int n_err;

  latch_rf_wr_sched #(
    .NUM_REQ    (4),
    .NUM_REGS   (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .cell_we_o    (cell_we_o),
    .cell_wdata_o (cell_wdata_o),
    .pending_o    (pending_o),
    .halt_req_i   (halt_req_i),
    .halted_o     (halted_o)
`ifdef LATCH_RF_WR_BYPASS_EN
    ,
    .rd_addr_i    (rd_addr_i),
    .byp_hit_o    (byp_hit_o),
    .byp_data_o   (byp_data_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][4:0]  addr;
    logic [3:0][31:0] data;
    logic             halt;
    logic [3:0]       exp_ready;
    logic [31:0]      exp_we;
    logic [31:0]      exp_wdata;
    logic             chk_wdata;
    logic [31:0]      exp_pend;
    logic             exp_halted;
  } vec_t;

  function automatic logic [31:0] onehot(input int i);
    onehot = (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  // Default requester i targets cell i+1 with data 0x10+i; req overrides one slot.
  function automatic vec_t row(input logic [3:0] valid, input int req, input logic [4:0] addr,
                               input logic [31:0] data, input logic halt, input logic [3:0] rdy,
                               input int we_idx, input logic [31:0] wd, input logic chk_wd,
                               input int pend_idx, input logic hlt);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.addr[2'(i)] = 5'(i + 1);
      v.data[2'(i)] = 32'h10 + 32'(i);
    end
    if (req >= 0) begin
      v.addr[2'(req)] = addr;
      v.data[2'(req)] = data;
    end
    v.valid      = valid;
    v.halt       = halt;
    v.exp_ready  = rdy;
    v.exp_we     = onehot(we_idx);
    v.exp_wdata  = wd;
    v.chk_wdata  = chk_wd;
    v.exp_pend   = onehot(pend_idx);
    v.exp_halted = hlt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid_i = v.valid;
    req_addr_i  = v.addr;
    req_data_i  = v.data;
    halt_req_i  = v.halt;
  endtask

  vec_t idle_v;
  vec_t vecs[$];

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_v = row(4'b0000, -1, 5'd0, 32'd0, 1'b0, 4'b0000, -1, 32'd0, 1'b1, -1, 1'b0);

    // Reset with every input active.
    rst_ni      = 1'b0;
    req_valid_i = 4'hF;
    req_addr_i  = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data_i  = {4{32'hFFFF_FFFF}};
    halt_req_i  = 1'b1;
`ifdef LATCH_RF_WR_BYPASS_EN
    rd_addr_i   = 5'd3;
`endif
    #3;
    chk("rst ready",   32'(req_ready_o), 32'd0);
    chk("rst we",      cell_we_o,        32'd0);
    chk("rst wdata",   cell_wdata_o,     32'd0);
    chk("rst pending", pending_o,        32'd0);
    chk("rst halted",  32'(halted_o),    32'd0);
`ifdef LATCH_RF_WR_BYPASS_EN
    chk("rst byp_hit",  32'(byp_hit_o), 32'd0);
    chk("rst byp_data", byp_data_o,     32'd0);
`endif
    repeat (2) @(posedge clk_i);
    #1 drive(idle_v);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //                 valid  req addr   data           halt rdy     we  wdata          chk pend hlt
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0001,  1, 32'h10,        1, -1, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0010,  2, 32'h11,        1,  1, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0100,  3, 32'h12,        1,  2, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b1000,  4, 32'h13,        1,  3, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0001,  1, 32'h10,        1,  4, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1,  1, 0));
    vecs.push_back(idle_v);
    vecs.push_back(row(4'b0100, 2, 5'd5, 32'hDEADBEEF,  0, 4'b0100,  5, 32'hDEADBEEF,  1, -1, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1,  5, 0));
    vecs.push_back(idle_v);
    vecs.push_back(row(4'b0010, 1, 5'd0, 32'h1234,      0, 4'b0010, -1, 32'h1234,      0, -1, 0));
    vecs.push_back(idle_v);
    vecs.push_back(row(4'b0001, 0, 5'd7, 32'hA,         0, 4'b0001,  7, 32'hA,         1, -1, 0));
    vecs.push_back(row(4'b0001, 0, 5'd7, 32'hB,         0, 4'b0001,  7, 32'hB,         1,  7, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1,  7, 0));
    vecs.push_back(idle_v);
    // Halt the cycle after a write: one DRAIN cycle, then HALTED.
    vecs.push_back(row(4'b0010, 1, 5'd9, 32'h99,        0, 4'b0010,  9, 32'h99,        1, -1, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         1, 4'b0000, -1, 32'd0,         1,  9, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         1, 4'b0000, -1, 32'd0,         1, -1, 0));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         1, 4'b0000, -1, 32'd0,         1, -1, 1));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1, -1, 1));
    vecs.push_back(row(4'hF,  -1, 5'd0,  32'd0,         0, 4'b0100,  3, 32'h12,        1, -1, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1,  3, 0));
    vecs.push_back(idle_v);
    // Halt with nothing pending goes straight to HALTED.
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         1, 4'b0000, -1, 32'd0,         1, -1, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         1, 4'b0000, -1, 32'd0,         1, -1, 1));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1, -1, 1));
    vecs.push_back(idle_v);
    // Halt dropped during DRAIN returns to RUN without halted_o.
    vecs.push_back(row(4'b1000, 3, 5'd10, 32'h3,       0, 4'b1000, 10, 32'h3,         1, -1, 0));
    vecs.push_back(row(4'b0001, -1, 5'd0, 32'd0,       1, 4'b0000, -1, 32'd0,         1, 10, 0));
    vecs.push_back(row(4'b0001, -1, 5'd0, 32'd0,       0, 4'b0000, -1, 32'd0,         1, -1, 0));
    vecs.push_back(row(4'b0001, -1, 5'd0, 32'd0,       0, 4'b0001,  1, 32'h10,        1, -1, 0));
    vecs.push_back(row(4'h0,  -1, 5'd0,  32'd0,         0, 4'b0000, -1, 32'd0,         1,  1, 0));

    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1 drive(vecs[i]);
      @(negedge clk_i);
      chk($sformatf("row%0d ready", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
      chk($sformatf("row%0d we", i), cell_we_o, vecs[i].exp_we);
      if (vecs[i].chk_wdata) chk($sformatf("row%0d wdata", i), cell_wdata_o, vecs[i].exp_wdata);
      chk($sformatf("row%0d pending", i), pending_o, vecs[i].exp_pend);
      chk($sformatf("row%0d halted", i), 32'(halted_o), 32'(vecs[i].exp_halted));
    end

    // Reset asserted while a pending bit is live clears it and the pointer.
    @(posedge clk_i);
    #1 drive(row(4'b0010, 1, 5'd6, 32'h66, 0, 4'b0010, 6, 32'h66, 1, -1, 0));
    @(negedge clk_i);
    chk("mid ready", 32'(req_ready_o), 32'b0010);
    chk("mid we",    cell_we_o,        onehot(6));
    @(posedge clk_i);
    #1 drive(idle_v);
    #1 chk("mid pending set", pending_o, onehot(6));
    rst_ni = 1'b0;
    #1 chk("mid pending cleared", pending_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 drive(row(4'hF, -1, 5'd0, 32'd0, 0, 4'b0001, 1, 32'h10, 1, -1, 0));
    @(negedge clk_i);
    chk("post-rst ready", 32'(req_ready_o), 32'b0001);
    chk("post-rst we",    cell_we_o,        onehot(1));

`ifdef LATCH_RF_WR_BYPASS_EN
    // Write 0x55 to cell 3, read it through the bypass next cycle.
    @(posedge clk_i);
    #1 drive(row(4'b0010, 1, 5'd3, 32'h55, 0, 4'b0010, 3, 32'h55, 1, -1, 0));
    rd_addr_i = 5'd3;
    @(negedge clk_i);
    chk("byp pre hit", 32'(byp_hit_o), 32'd0);
    @(posedge clk_i);
    #1 drive(idle_v);
    @(negedge clk_i);
    chk("byp hit",  32'(byp_hit_o), 32'd1);
    chk("byp data", byp_data_o,     32'h55);
    rd_addr_i = 5'd4;
    #1 chk("byp miss", 32'(byp_hit_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/latch_rf_wr_sched.md
# latch_rf_wr_sched

Write-port scheduler for a bank of latch-based register cells, each with a one-cycle sampled write and a gated latch. It shares the bank's single write port among NUM_REQ requesters using round-robin arbitration, decodes the granted address into per-cell write enables, and broadcasts the write data. A pending bitmap tells readers which cells are not yet stable. A halt/drain state machine lets the core quiesce the register file, for example before test-mode clock-gate override or context save.

## Interface
- NUM_REQ, 4: number of write requesters (2..8)
- NUM_REGS, 32: number of latch cells; cell 0 is hardwired zero
- DATA_WIDTH, 32: cell data width
- AW, $clog2(NUM_REGS): address width (derived)

- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  write request per requester
- req_addr_i  in  NUM_REQ×AW  target cell per requester
- req_data_i  in  NUM_REQ×DATA_WIDTH  write data per requester
- req_ready_o  out  NUM_REQ  one-hot grant; handshake completes on valid&ready
- cell_we_o  out  NUM_REGS  per-cell write enable, one-hot or zero
- cell_wdata_o  out  DATA_WIDTH  broadcast write data for all cells
- pending_o  out  NUM_REGS  cell written last cycle; its read data is not yet valid
- halt_req_i  in  1  level request to stop granting
- halted_o  out  1  no write in flight, none will be granted

## Operation
- Requester protocol: requester i holds valid, addr and data stable until req_ready_o[i]=1. At most one grant per cycle.
- Arbitration is round-robin. Priority starts at pointer ptr. After a grant to requester i, ptr becomes (i+1) mod NUM_REQ. If there is no grant, ptr holds. Reset sets ptr to 0.
- Grant cycle T:
  - cell_we_o[addr]=1 and cell_wdata_o=req_data_i[i], both combinational in T.
  - pending_o[addr]=1 is registered and asserted in T+1 only.
- addr 0, or addr ≥ NUM_REGS:
  - The request is granted and the handshake completes.
  - cell_we_o stays zero and no pending bit is set. The write is silently dropped.
- Same cell written in T and T+1: both are granted; the last write wins. pending_o stays asserted through T+2.
- When no request is granted, cell_we_o=0 and cell_wdata_o=0.
- State machine, encoded in the state_t enum:
  - RUN: grants enabled. halt_req_i=1 moves to DRAIN; grants are suppressed in that same cycle.
  - DRAIN: no grants. Moves to HALTED when pending_o==0, which takes at most 1 cycle.
  - HALTED: no grants; halted_o=1. halt_req_i=0 moves to RUN; grants resume the following cycle.
  - halt_req_i deasserted while in DRAIN: complete the drain, then go to RUN without asserting halted_o.

## Timing
- Reset values: req_ready_o=0, cell_we_o=0, cell_wdata_o=0, pending_o=0, halted_o=0, state=RUN, ptr=0. Combinational outputs are forced to 0 while rst_ni=0.
- Grant-to-cell-enable latency is 0 cycles. Grant-to-pending latency is 1 cycle.
- Readers may sample cell data from T+2 onward.
- halt_req_i rising in cycle T gives halted_o=1 at T+1 if no write was granted in T-1, otherwise at T+2.
- Reset asserted mid-write: the in-flight pending bit is cleared. Cell contents are owned by the cell's own reset.

## Configuration
- LATCH_RF_WR_BYPASS_EN adds ports rd_addr_i (in, AW), byp_hit_o (out, 1) and byp_data_o (out, DATA_WIDTH).
- Behaviour with the macro defined:
  - A registered copy of the last granted address and data is kept.
  - byp_hit_o=1 when pending_o[rd_addr_i]=1. byp_data_o is the data written in the previous cycle; reset value 0.
  - Readers may then consume a cell at T+1.
- Without the macro these ports and the copy registers do not exist, and readers must stall on pending_o.

## Structure
- Package latch_rf_pkg holds:
  - state_t enum {RUN, DRAIN, HALTED}
  - the AW derivation function
  - parameter defaults
- Sub-module rr_arbiter (NUM_REQ) holds the pointer register and produces the one-hot grant from valid, an enable, and ptr.
- The top level contains the decoder, pending register, FSM and optional bypass.

## Test plan
- Reset with all inputs active -> all outputs 0. After release, a single request from req 2 (addr 5, data 0xDEADBEEF) -> ready[2]=1 and cell_we_o[5]=1 in the same cycle; pending_o[5]=1 next cycle, then clears.
- All four requesters valid continuously -> grants in order 0,1,2,3,0 with one grant per cycle and no starvation.
- Request to addr 0 with data 0x1234 -> handshake completes; cell_we_o==0; pending_o==0.
- Back-to-back writes to addr 7 (0xA, then 0xB) -> both granted; pending_o[7] high for 2 cycles; cell ends at 0xB.
- halt_req_i raised the cycle after a write -> DRAIN for 1 cycle, halted_o=1, no grants despite valid requests. Drop halt_req_i -> grant resumes the next cycle.
- With LATCH_RF_WR_BYPASS_EN: write 0x55 to addr 3, with rd_addr_i=3 in the next cycle -> byp_hit_o=1 and byp_data_o=0x55.
